// File: rtl/rs232_tx_arb.sv
// Line-granular round-robin arbiter in front of one byte-wide serial transmitter.
// One arbitration cycle per grant; byte handshake is a combinational pass-through while locked.
module rs232_tx_arb #(
    parameter int          N        = 4,
    parameter int          TIMEOUT  = 1024,
    parameter int          MAX_LINE = 128,
    parameter logic [7:0]  EOL      = 8'h0A,
    localparam int         GW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_val,
    input  logic [N*8-1:0]  req_bits,
    output logic [N-1:0]    req_rdy,
    input  logic            tx_rdy,
    output logic            tx_val,
    output logic [7:0]      tx_bits,
    output logic [GW-1:0]   gnt_id,
    output logic            busy
);

    localparam int IW = $clog2(TIMEOUT);
    localparam int LW = $clog2(MAX_LINE + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [GW-1:0]  last_q, last_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic [LW-1:0]  len_q, len_d;

    logic           pick_found;
    logic [GW-1:0]  pick_idx;
    logic [GW-1:0]  cand;
    logic           g_val;
    logic [7:0]     g_bits;
    logic           xfer;
    logic           rel;

    // Search starts just after the previous grantee, so it ends up lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = last_q;
        for (int k = 1; k <= N; k++) begin
            cand = GW'((int'(last_q) + k) % N);
            if (!pick_found && req_val[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        g_val   = 1'b0;
        g_bits  = 8'h00;
        req_rdy = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q == GW'(i)) begin
                g_val      = req_val[i];
                g_bits     = req_bits[i*8 +: 8];
                req_rdy[i] = busy & tx_rdy;
            end
        end
    end

    assign busy    = (state_q == LOCKED);
    assign tx_val  = busy & g_val;
    assign tx_bits = g_bits;
    assign gnt_id  = gnt_q;
    assign xfer    = tx_val & tx_rdy;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        idle_d  = idle_q;
        len_d   = len_q;
        rel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    gnt_d   = pick_idx;
                    idle_d  = '0;
                    len_d   = '0;
                end
            end
            LOCKED: begin
                // A stalled byte (valid but transmitter not ready) is not idle time.
                if (xfer) begin
                    len_d  = len_q + LW'(1);
                    idle_d = '0;
                    rel    = (g_bits == EOL) || (len_q + LW'(1) == LW'(MAX_LINE));
                end else if (!g_val) begin
                    idle_d = idle_q + IW'(1);
                    rel    = (idle_q == IW'(TIMEOUT - 1));
                end
                if (rel) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(N - 1);
            idle_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            idle_q  <= idle_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Bench for rs232_tx_arb: directed vector table, directed line sequences, then random traffic
// compared every cycle against a line-level reference model.
module tb_rs232_tx_arb;

    localparam int         N    = 4;
    localparam int         TO   = 8;
    localparam int         ML   = 4;
    localparam logic [7:0] EOLB = 8'h0A;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_val;
    logic [N*8-1:0]  req_bits;
    logic [N-1:0]    req_rdy;
    logic            tx_rdy;
    logic            tx_val;
    logic [7:0]      tx_bits;
    logic [1:0]      gnt_id;
    logic            busy;

    always #5 clk = ~clk;

    rs232_tx_arb #(.N(N), .TIMEOUT(TO), .MAX_LINE(ML), .EOL(EOLB)) dut (
        .clk(clk), .rst(rst), .req_val(req_val), .req_bits(req_bits), .req_rdy(req_rdy),
        .tx_rdy(tx_rdy), .tx_val(tx_val), .tx_bits(tx_bits), .gnt_id(gnt_id), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the line, bytes sent in it, consecutive quiet cycles.
    bit m_locked;
    int m_owner, m_last, m_len, m_quiet;

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_last = N - 1; m_len = 0; m_quiet = 0;
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic       ev;
        logic [N-1:0] er;
        ev = m_locked && req_val[m_owner];
        er = '0;
        if (m_locked) er[m_owner] = tx_rdy;
        chk("tx_val", tx_val, ev);
        if (ev) chk("tx_bits", tx_bits, req_bits[m_owner*8 +: 8]);
        chk("req_rdy", req_rdy, er);
        chk("busy", busy, m_locked);
        chk("gnt_id", gnt_id, m_owner);
    endtask

    task automatic model_update();
        int c;
        bit done;
        done = 0;
        if (rst) begin
            model_reset();
        end else if (!m_locked) begin
            c = rr_next(m_last, req_val);
            if (c >= 0) begin
                m_locked = 1; m_owner = c; m_len = 0; m_quiet = 0;
            end
        end else begin
            if (req_val[m_owner] && tx_rdy) begin
                m_len++;
                m_quiet = 0;
                done = (req_bits[m_owner*8 +: 8] == EOLB) || (m_len == ML);
            end else if (!req_val[m_owner]) begin
                m_quiet++;
                done = (m_quiet == TO);
            end
            if (done) begin
                m_locked = 0;
                m_last = m_owner;
            end
        end
    endtask

    // Observations of the DUT itself: grantee per line, bytes per line, locked cycles per id.
    int dut_grants[$];
    int line_lens[$];
    int busy_cycles[N];
    bit prev_busy;
    int cur_len;

    task automatic observe();
        if (busy && !prev_busy) begin
            dut_grants.push_back(int'(gnt_id));
            cur_len = 0;
        end
        if (busy) busy_cycles[gnt_id]++;
        if (tx_val && tx_rdy) cur_len++;
        if (!busy && prev_busy) line_lens.push_back(cur_len);
        prev_busy = busy;
    endtask

    task automatic clear_logs();
        dut_grants.delete();
        line_lens.delete();
        for (int i = 0; i < N; i++) busy_cycles[i] = 0;
    endtask

    // Requesters: each owns a byte queue and holds a presented byte until accepted.
    logic [7:0] src_q[N][$];
    bit         pres[N];
    int         en_pct = 100;
    bit         rdy_rand = 0;

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pres[i] && src_q[i].size() > 0 && ($urandom_range(99) < en_pct)) pres[i] = 1;
            req_val[i] = pres[i];
            req_bits[i*8 +: 8] = pres[i] ? src_q[i][0] : 8'($urandom);
        end
        tx_rdy = rdy_rand ? ($urandom_range(2) != 0) : 1'b1;
    endtask

    task automatic finish_cycle();
        model_check();
        observe();
        for (int i = 0; i < N; i++) begin
            if (m_locked && m_owner == i && req_val[i] && tx_rdy) begin
                void'(src_q[i].pop_front());
                pres[i] = 0;
            end
        end
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        drive();
        #1;
        finish_cycle();
    endtask

    task automatic run_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((any_pending() || m_locked) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required drain", name, n);
        end
        cycle();
    endtask

    task automatic check_log(input string name, input int eg[$], input int el[$]);
        chk({name, "_lines"}, dut_grants.size(), eg.size());
        for (int i = 0; i < eg.size() && i < dut_grants.size(); i++)
            chk($sformatf("%s_grant%0d", name, i), dut_grants[i], eg[i]);
        chk({name, "_lencount"}, line_lens.size(), el.size());
        for (int i = 0; i < el.size() && i < line_lens.size(); i++)
            chk($sformatf("%s_len%0d", name, i), line_lens[i], el[i]);
    endtask

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [7:0] b0;
        logic       tr;
        logic       ev;
        logic [7:0] eb;
        logic [3:0] er;
        logic       ebusy;
        logic [1:0] eg;
    } vec_t;

    vec_t tv[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int eg[$];
        int el[$];
        int n;

        rst = 1'b1; req_val = '0; req_bits = '0; tx_rdy = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) pres[i] = 0;
        prev_busy = 0; cur_len = 0;
        clear_logs();
        @(negedge clk);
        @(negedge clk);

        // "AB\n" from requester 0, then a line with tx_rdy 1,0,0,1 mid-line.
        tv[0]  = '{1'b1, 4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tv[1]  = '{1'b0, 4'b0001, 8'h41, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tv[2]  = '{1'b0, 4'b0001, 8'h41, 1'b1, 1'b1, 8'h41, 4'b0001, 1'b1, 2'd0};
        tv[3]  = '{1'b0, 4'b0001, 8'h42, 1'b1, 1'b1, 8'h42, 4'b0001, 1'b1, 2'd0};
        tv[4]  = '{1'b0, 4'b0001, 8'h0A, 1'b1, 1'b1, 8'h0A, 4'b0001, 1'b1, 2'd0};
        tv[5]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tv[6]  = '{1'b0, 4'b0001, 8'h43, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tv[7]  = '{1'b0, 4'b0001, 8'h43, 1'b1, 1'b1, 8'h43, 4'b0001, 1'b1, 2'd0};
        tv[8]  = '{1'b0, 4'b0001, 8'h44, 1'b0, 1'b1, 8'h44, 4'b0000, 1'b1, 2'd0};
        tv[9]  = '{1'b0, 4'b0001, 8'h44, 1'b0, 1'b1, 8'h44, 4'b0000, 1'b1, 2'd0};
        tv[10] = '{1'b0, 4'b0001, 8'h44, 1'b1, 1'b1, 8'h44, 4'b0001, 1'b1, 2'd0};
        tv[11] = '{1'b0, 4'b0001, 8'h0A, 1'b1, 1'b1, 8'h0A, 4'b0001, 1'b1, 2'd0};
        tv[12] = '{1'b0, 4'b0000, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};

        for (int k = 0; k < 13; k++) begin
            rst = tv[k].r;
            req_val = tv[k].v;
            req_bits = {24'h0, tv[k].b0};
            tx_rdy = tv[k].tr;
            #1;
            chk($sformatf("vec%0d_tx_val", k), tx_val, tv[k].ev);
            if (tv[k].ev) chk($sformatf("vec%0d_tx_bits", k), tx_bits, tv[k].eb);
            chk($sformatf("vec%0d_req_rdy", k), req_rdy, tv[k].er);
            chk($sformatf("vec%0d_busy", k), busy, tv[k].ebusy);
            chk($sformatf("vec%0d_gnt_id", k), gnt_id, tv[k].eg);
            observe();
            model_update();
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;

        // Requesters 0 and 2 both stream "x\n" twice; previous grantee was 0.
        clear_logs();
        src_q[0] = '{8'h78, 8'h0A, 8'h78, 8'h0A};
        src_q[2] = '{8'h78, 8'h0A, 8'h78, 8'h0A};
        run_drain("rr", 200);
        eg = '{2, 0, 2, 0}; el = '{2, 2, 2, 2};
        check_log("rr", eg, el);

        // Grantee 1 sends one byte then goes quiet while requester 3 waits.
        clear_logs();
        src_q[1] = '{8'h61};
        src_q[3] = '{8'h71, 8'h0A};
        run_drain("idle_to", 200);
        eg = '{1, 3}; el = '{1, 2};
        check_log("idle_to", eg, el);
        chk("idle_to_locked_cycles", busy_cycles[1], 1 + TO);

        // Requester 0 streams without EOL while requester 1 waits.
        clear_logs();
        src_q[0] = '{8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h7A, 8'h7A};
        src_q[1] = '{8'h77, 8'h0A};
        run_drain("maxline", 300);
        eg = '{0, 1, 0}; el = '{4, 2, 2};
        check_log("maxline", eg, el);

        // Reset after 2 of 5 bytes from requester 2 while requester 0 also waits.
        clear_logs();
        src_q[2] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h0A};
        src_q[0] = '{8'h72, 8'h0A};
        n = 0;
        while (src_q[2].size() > 3 && n < 50) begin
            cycle();
            n++;
        end
        chk("rst_prefix_bytes", src_q[2].size(), 3);
        rst = 1'b1;
        drive();
        tx_rdy = 1'b0;
        #1;
        finish_cycle();
        rst = 1'b0;
        drive();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_val", tx_val, 1'b0);
        chk("rst_req_rdy", req_rdy, 4'b0000);
        finish_cycle();
        run_drain("rst", 200);
        eg = '{2, 0, 2}; el = '{2, 2, 3};
        check_log("rst", eg, el);

        // Random traffic: random line lengths, optional EOL, random stalls, rare resets.
        en_pct = 60;
        rdy_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(9) == 0) begin
                    int len;
                    len = int'($urandom_range(6, 1));
                    for (int b = 0; b < len - 1; b++) src_q[i].push_back(8'(8'h20 + $urandom_range(90)));
                    if ($urandom_range(3) != 0) src_q[i].push_back(EOLB);
                    else src_q[i].push_back(8'(8'h20 + $urandom_range(90)));
                end
            end
            rst = ($urandom_range(499) == 0);
            cycle();
        end
        rst = 1'b0;
        en_pct = 100;
        rdy_rand = 0;
        run_drain("random", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
